// File: rtl/continuous_monitoring_system_pkg.sv
// -----------------------------------------------------------------------------
// continuous_monitoring_system_pkg
// Shared types and widths for the continuous monitoring pipeline.
//   RISC_V_INSTRUCTION_WIDTH : width of a RISC-V instruction word.
//   TRACE_PC_WIDTH           : width of the pc field stored in a trace entry.
//   TRACE_CNT_WIDTH          : width of the optional timestamp field.
//   trace_entry_t            : {pc, instr[, timestamp]}.
//   buf_state_t              : trace buffer occupancy state.
// Build option: TRACE_BUFFER_TIMESTAMP_EN adds the timestamp field.
// -----------------------------------------------------------------------------
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int TRACE_PC_WIDTH           = 64;
  localparam int TRACE_CNT_WIDTH          = 32;

  typedef struct packed {
    logic [TRACE_PC_WIDTH-1:0]           pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [TRACE_CNT_WIDTH-1:0]          timestamp;
`else
    // Without timestamps an entry is just {pc, instr}.
`endif
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/trace_item_buffer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset.
//   clr        : synchronous clear to zero (wins over inc).
//   inc        : count up by one unless already at all-ones.
//   count      : current value.
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/trace_item_buffer.sv
// -----------------------------------------------------------------------------
// trace_item_buffer
// Captures trace items not dropped by trace_filter into a circular FIFO and
// presents them on a valid/ready export port, with saturating statistics.
//   clk, rst_n       : clock, asynchronous active-low reset.
//   item_valid, pc,
//   instr, drop_instr: incoming trace item and the filter's drop decision.
//   clear            : synchronous flush of FIFO, overflow flag and counters.
//   m_valid, m_ready,
//   m_data           : export handshake; m_data is the head entry.
//   overflow         : sticky, a kept item was lost since reset/clear.
//   kept_count, dropped_count, lost_count : saturating statistics.
//   fill_level       : current occupancy.
// Build option: TRACE_BUFFER_TIMESTAMP_EN adds a saturating cycle counter whose
// value at the push cycle is stored in each entry.
// -----------------------------------------------------------------------------
module trace_item_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_WIDTH  = TRACE_PC_WIDTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                item_valid,
  input  logic [PC_WIDTH-1:0]                 pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
  input  logic                                drop_instr,
  input  logic                                clear,
  output logic                                m_valid,
  input  logic                                m_ready,
  output trace_entry_t                        m_data,
  output logic                                overflow,
  output logic [CNT_WIDTH-1:0]                kept_count,
  output logic [CNT_WIDTH-1:0]                dropped_count,
  output logic [CNT_WIDTH-1:0]                lost_count,
  output logic [$clog2(DEPTH):0]              fill_level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  trace_entry_t            mem [DEPTH];
  trace_entry_t            wr_entry;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [FILL_W-1:0]       fill_next;
  buf_state_t              state;
  buf_state_t              state_next;

  logic push_req;
  logic push_ok;
  logic pop;
  logic drop_hit;
  logic lost_hit;

  // The state register mirrors occupancy so valid/full come straight from flops.
  assign m_valid  = (state != IDLE);
  assign pop      = m_valid & m_ready;
  assign push_req = item_valid & ~drop_instr;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok  = push_req & ((state != FULL) | pop);
  assign lost_hit = push_req & ~push_ok;
  assign drop_hit = item_valid & drop_instr;

  assign fill_next = fill_level + FILL_W'(push_ok) - FILL_W'(pop);

  // Head is read combinationally so it is valid in the cycle after the write.
  assign m_data = m_valid ? mem[rd_ptr] : '0;

`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] ts_count;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_ts_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(1'b1), .count(ts_count)
  );
`else
  // No cycle counter in this build.
`endif

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = TRACE_PC_WIDTH'(pc);
    wr_entry.instr = instr;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    wr_entry.timestamp = TRACE_CNT_WIDTH'(ts_count);
`else
    // Entry carries only pc and instr.
`endif
  end

  // Storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
    end else begin
      state <= state_next;
      if (clear) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fill_level <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (lost_hit) overflow <= 1'b1;
        fill_level <= fill_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (fill_next == '0) begin
      state_next = IDLE;
    end else if (fill_next == FILL_W'(DEPTH)) begin
      state_next = FULL;
    end else begin
      state_next = ACTIVE;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_kept_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(push_ok), .count(kept_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(drop_hit), .count(dropped_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_lost_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(lost_hit), .count(lost_count)
  );

endmodule

// File: tb/tb_trace_item_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_item_buffer
// Scoreboard bench: the stimulus side keeps a queue-based model of the buffer
// and pushes every accepted item; an independent monitor checks the head entry
// against the queue front on every valid cycle and pops on handshake.
// -----------------------------------------------------------------------------
module tb_trace_item_buffer;
  import continuous_monitoring_system_pkg::*;

  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 32;
  localparam int FILL_W    = $clog2(DEPTH) + 1;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_WIDTH) - 1;

  logic                                clk;
  logic                                rst_n;
  logic                                item_valid;
  logic [TRACE_PC_WIDTH-1:0]           pc;
  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
  logic                                drop_instr;
  logic                                clear;
  logic                                m_valid;
  logic                                m_ready;
  trace_entry_t                        m_data;
  logic                                overflow;
  logic [CNT_WIDTH-1:0]                kept_count;
  logic [CNT_WIDTH-1:0]                dropped_count;
  logic [CNT_WIDTH-1:0]                lost_count;
  logic [FILL_W-1:0]                   fill_level;

  trace_item_buffer #(
    .DEPTH(DEPTH), .PC_WIDTH(TRACE_PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .item_valid(item_valid), .pc(pc), .instr(instr),
    .drop_instr(drop_instr), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .overflow(overflow), .kept_count(kept_count),
    .dropped_count(dropped_count), .lost_count(lost_count), .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state.
  trace_entry_t    exp_q[$];
  int              model_fill;
  longint unsigned m_kept, m_dropped, m_lost, m_ts;
  bit              m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic chk_entry(input string name, input trace_entry_t act, input trace_entry_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_fill = 0;
    m_kept = 0; m_dropped = 0; m_lost = 0; m_ts = 0;
    m_ovf = 1'b0;
  endtask

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Monitor: head must always equal the oldest model entry; a held head must not move.
  trace_entry_t held;
  bit           hold_pending = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (hold_pending && m_valid === 1'b1) chk_entry("hold_stable", m_data, held);
      if (m_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL head: DUT valid with data %h, model empty", m_data);
        end else begin
          chk_entry("head", m_data, exp_q[0]);
          if (m_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
      hold_pending = (m_valid === 1'b1) && (m_ready === 1'b0);
      held         = m_data;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic check_state(input string tag);
    chk({tag, ".fill_level"}, 64'(fill_level), 64'(model_fill));
    chk({tag, ".m_valid"}, 64'(m_valid), 64'(model_fill != 0));
    chk({tag, ".kept"}, 64'(kept_count), m_kept);
    chk({tag, ".dropped"}, 64'(dropped_count), m_dropped);
    chk({tag, ".lost"}, 64'(lost_count), m_lost);
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  // One cycle: called at posedge+1, returns at the next posedge+1 after checking.
  task automatic step(input bit iv, input bit dr, input bit rdy, input bit clr);
    trace_entry_t e;
    int  pre;
    bit  pop_m, push_m, acc;
    item_valid = iv;
    drop_instr = dr;
    m_ready    = rdy;
    clear      = clr;
    pc         = {$urandom(), $urandom()};
    instr      = $urandom();
    e          = '0;
    e.pc       = pc;
    e.instr    = instr;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    e.timestamp = m_ts[TRACE_CNT_WIDTH-1:0];
`endif
    #5;  // let the monitor sample this cycle's head first
    if (clr) begin
      exp_q.delete();
      model_fill = 0;
      m_kept = 0; m_dropped = 0; m_lost = 0;
      m_ovf = 1'b0;
    end else begin
      pre    = model_fill;
      pop_m  = (pre > 0) && rdy;
      push_m = iv && !dr;
      acc    = push_m && ((pre < DEPTH) || pop_m);
      if (iv && dr) m_dropped = sat_inc(m_dropped);
      if (acc) begin
        m_kept = sat_inc(m_kept);
        exp_q.push_back(e);
      end
      if (push_m && !acc) begin
        m_lost = sat_inc(m_lost);
        m_ovf  = 1'b1;
      end
      model_fill = pre + int'(acc) - int'(pop_m);
    end
    @(posedge clk);
    #1;
    m_ts = clr ? 0 : sat_inc(m_ts);
    check_state("step");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.m_valid", 64'(m_valid), 64'd0);
    chk("rst.fill_level", 64'(fill_level), 64'd0);
    chk("rst.m_data", 64'(m_data != '0), 64'd0);
    chk("rst.kept", 64'(kept_count), 64'd0);
    chk("rst.dropped", 64'(dropped_count), 64'd0);
    chk("rst.lost", 64'(lost_count), 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain.queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  bit split_pat [10] = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    rst_n = 1'b0; item_valid = 1'b0; drop_instr = 1'b0; clear = 1'b0;
    m_ready = 1'b0; pc = '0; instr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Asynchronous reset with stored items, then one push shows up a cycle later.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset.fill", 64'(fill_level), 64'd5);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_reset.m_valid", 64'(m_valid), 64'd1);
    drain();

    // Filter split.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, split_pat[i], 1'b1, 1'b0);
    drain();
    chk("split.kept", 64'(kept_count), 64'd7);
    chk("split.dropped", 64'(dropped_count), 64'd3);

    // Overflow, then a push while full together with a pop.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf.fill", 64'(fill_level), 64'd16);
    chk("ovf.kept", 64'(kept_count), 64'd16);
    chk("ovf.lost", 64'(lost_count), 64'd4);
    chk("ovf.flag", 64'(overflow), 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("fullpop.fill", 64'(fill_level), 64'd16);
    chk("fullpop.lost", 64'(lost_count), 64'd4);
    drain();

    // Back-pressure with pointer wrap: 40 items over 60 cycles, ready toggling.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step((i % 3) != 0, 1'b0, (i % 2) == 0, 1'b0);
    drain();
    chk("bp.kept", 64'(kept_count), 64'd40);
    chk("bp.lost", 64'(lost_count), 64'd0);

    // Clear priority over a push with fill=3 and overflow set.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("preclr.fill", 64'(fill_level), 64'd3);
    chk("preclr.ovf", 64'(overflow), 64'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("clr.fill", 64'(fill_level), 64'd0);
    chk("clr.m_valid", 64'(m_valid), 64'd0);
    chk("clr.ovf", 64'(overflow), 64'd0);
    chk("clr.kept", 64'(kept_count), 64'd0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step(($urandom() % 4) != 0, ($urandom() % 4) == 0,
           ($urandom() % 3) != 0, ($urandom() % 64) == 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
